// File: rtl/usb_bit_stuffer_param_pkg.sv
// Shared types and constants for the USB transmit path.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_SKIP,
    BS_COUNT,
    BS_STUFF
  } bs_state_t;

  localparam int unsigned USB_RUN_LEN     = 6;
  localparam int unsigned USB_PID_BITS    = 8;
  localparam int unsigned USB_STUFF_CNT_W = 8;

  // Width of a counter that must hold values up to max(run_len, skip_bits).
  function automatic int unsigned bs_cnt_width(input int unsigned run_len,
                                               input int unsigned skip_bits);
    int unsigned m;
    m = (run_len > skip_bits) ? run_len : skip_bits;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/usb_bit_stuffer_param_if.sv
// Bit-stream handshake bundle between the CRC appender, the stuffer and the NRZI encoder.
interface usb_bit_stuffer_param_if
  import usb_tx_pkg::*;
  ();

  logic                       in_valid;
  logic                       in_bit;
  logic                       in_last;
  logic                       in_ready;
  logic                       stuff_en;
  logic                       out_valid;
  logic                       out_bit;
  logic                       out_last;
  logic                       out_stuffed;
  logic                       out_ready;
  logic [USB_STUFF_CNT_W-1:0] stuff_cnt;
  logic                       busy;

  // Driving side: upstream source plus downstream sink.
  modport master (
    output in_valid, in_bit, in_last, stuff_en, out_ready,
    input  in_ready, out_valid, out_bit, out_last, out_stuffed, stuff_cnt, busy
  );

  // Stuffer side.
  modport slave (
    input  in_valid, in_bit, in_last, stuff_en, out_ready,
    output in_ready, out_valid, out_bit, out_last, out_stuffed, stuff_cnt, busy
  );

endinterface

// File: rtl/usb_bs_out_reg.sv
// Single-entry output register: captures a word on load, holds it until the
// downstream accepts, and reports whether a new word can be taken this cycle.
module usb_bs_out_reg #(
  parameter int unsigned W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         can_load
);

  assign can_load = ~valid | ready;

  // Capture on load, otherwise drop valid once the current word is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_bit_stuffer_param.sv
// NRZ bit stuffer: after RUN_LEN consecutive MATCH_VAL bits, insert one
// STUFF_VAL bit. The first SKIP_BITS bits of a packet (the PID) pass untouched.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   BS_IDLE  | waiting for the first bit of a packet
//   BS_SKIP  | passing leading bits through, counting them in bit_cnt
//   BS_COUNT | passing bits through, tracking the MATCH_VAL run in run_cnt
//   BS_STUFF | input stalled, emitting one stuff bit
module usb_bit_stuffer_param
  import usb_tx_pkg::*;
#(
  parameter int unsigned RUN_LEN   = USB_RUN_LEN,
  parameter int unsigned SKIP_BITS = USB_PID_BITS,
  parameter logic        MATCH_VAL = 1'b1,
  parameter logic        STUFF_VAL = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  usb_bit_stuffer_param_if.slave bus
);

  localparam int unsigned CW      = bs_cnt_width(RUN_LEN, SKIP_BITS);
  localparam logic [CW-1:0] RUN_TC  = CW'(RUN_LEN);
  localparam logic [CW-1:0] SKIP_TC = CW'(SKIP_BITS);

  bs_state_t                  state;
  logic [CW-1:0]              run_cnt;
  logic [CW-1:0]              bit_cnt;
  logic                       pkt_stuff;
  logic                       pend_last;
  logic [USB_STUFF_CNT_W-1:0] stuff_cnt;

  logic          in_ready;
  logic          in_fire;
  logic          is_first;
  logic          counting;
  logic          match_run;
  logic [CW-1:0] run_next;
  logic [CW-1:0] bit_next;
  logic          trig;
  logic          load;
  logic [2:0]    load_d;
  logic          can_load;
  logic          out_valid;
  logic [2:0]    out_q;

  // Decode the accepted bit: run tracking, stuff trigger and output-register load word.
  always_comb begin
    in_ready  = can_load & (state != BS_STUFF);
    in_fire   = bus.in_valid & in_ready;
    is_first  = (state == BS_IDLE);
    // With no skip window the first bit of a packet is already a counted bit.
    counting  = (state == BS_COUNT) | (is_first & (SKIP_BITS == 0));
    match_run = (bus.in_bit == MATCH_VAL) & (is_first ? bus.stuff_en : pkt_stuff);
    run_next  = match_run ? ((is_first ? '0 : run_cnt) + 1'b1) : '0;
    bit_next  = (is_first ? '0 : bit_cnt) + 1'b1;
    trig      = in_fire & counting & (run_next == RUN_TC);
    if (state == BS_STUFF) begin
      load   = can_load;
      load_d = {STUFF_VAL, pend_last, 1'b1};
    end else begin
      load   = in_fire;
      // A bit that triggers a stuff hands its last flag over to the stuff bit.
      load_d = {bus.in_bit, bus.in_last & ~trig, 1'b0};
    end
  end

  // Packet sequencing and per-packet counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BS_IDLE;
      run_cnt   <= '0;
      bit_cnt   <= '0;
      pkt_stuff <= 1'b0;
      pend_last <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      case (state)
        BS_IDLE, BS_SKIP, BS_COUNT: begin
          if (in_fire) begin
            if (is_first) begin
              pkt_stuff <= bus.stuff_en;
              stuff_cnt <= '0;
              run_cnt   <= '0;
              bit_cnt   <= '0;
            end
            if (counting) begin
              if (trig) begin
                run_cnt   <= '0;
                pend_last <= bus.in_last;
                state     <= BS_STUFF;
              end else begin
                run_cnt <= run_next;
                state   <= bus.in_last ? BS_IDLE : BS_COUNT;
              end
            end else begin
              bit_cnt <= bit_next;
              if (bus.in_last)
                state <= BS_IDLE;
              else if (bit_next == SKIP_TC)
                state <= BS_COUNT;
              else
                state <= BS_SKIP;
            end
          end
        end
        BS_STUFF: begin
          if (can_load) begin
            if (stuff_cnt != '1)
              stuff_cnt <= stuff_cnt + 1'b1;
            state <= pend_last ? BS_IDLE : BS_COUNT;
          end
        end
        default: state <= BS_IDLE;
      endcase
    end
  end

  usb_bs_out_reg #(.W(3)) u_out_reg (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .d        (load_d),
    .ready    (bus.out_ready),
    .valid    (out_valid),
    .q        (out_q),
    .can_load (can_load)
  );

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_bit     = out_q[2];
  assign bus.out_last    = out_q[1];
  assign bus.out_stuffed = out_q[0];
  assign bus.stuff_cnt   = stuff_cnt;
  assign bus.busy        = (state != BS_IDLE) | out_valid;

endmodule

// File: tb/tb_usb_bit_stuffer_param.sv
// Scoreboard bench for the bit stuffer: default instance (RUN_LEN=6, 8-bit PID)
// and a short-run instance (RUN_LEN=3, no skip).
module tb_usb_bit_stuffer_param;
  import usb_tx_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  usb_bit_stuffer_param_if bus_a ();
  usb_bit_stuffer_param_if bus_b ();

  usb_bit_stuffer_param dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  usb_bit_stuffer_param #(
    .RUN_LEN   (3),
    .SKIP_BITS (0),
    .MATCH_VAL (1'b1),
    .STUFF_VAL (1'b0)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  logic sel = 1'b0;
  logic tb_in_valid = 1'b0;
  logic tb_in_bit = 1'b0;
  logic tb_in_last = 1'b0;
  logic tb_stuff_en = 1'b0;
  logic tb_out_ready = 1'b1;

  assign bus_a.in_valid  = tb_in_valid & ~sel;
  assign bus_a.in_bit    = tb_in_bit;
  assign bus_a.in_last   = tb_in_last;
  assign bus_a.stuff_en  = tb_stuff_en;
  assign bus_a.out_ready = tb_out_ready;
  assign bus_b.in_valid  = tb_in_valid & sel;
  assign bus_b.in_bit    = tb_in_bit;
  assign bus_b.in_last   = tb_in_last;
  assign bus_b.stuff_en  = tb_stuff_en;
  assign bus_b.out_ready = tb_out_ready;

  wire       obs_in_ready    = sel ? bus_b.in_ready    : bus_a.in_ready;
  wire       obs_out_valid   = sel ? bus_b.out_valid   : bus_a.out_valid;
  wire       obs_out_bit     = sel ? bus_b.out_bit     : bus_a.out_bit;
  wire       obs_out_last    = sel ? bus_b.out_last    : bus_a.out_last;
  wire       obs_out_stuffed = sel ? bus_b.out_stuffed : bus_a.out_stuffed;
  wire [7:0] obs_stuff_cnt   = sel ? bus_b.stuff_cnt   : bus_a.stuff_cnt;
  wire       obs_busy        = sel ? bus_b.busy        : bus_a.busy;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0]  exp_q[$];
  logic [63:0] pkt;
  int          pkt_n;
  int          pops;
  int          drops;
  logic [2:0]  last_got;
  logic [2:0]  prev_got;
  int          exp_sc;

  task automatic clear_pkt();
    pkt   = '0;
    pkt_n = 0;
  endtask

  task automatic add_bits(input logic [31:0] v, input int cnt);
    for (int i = cnt - 1; i >= 0; i--) begin
      pkt[pkt_n] = v[i];
      pkt_n++;
    end
  endtask

  // Reference model: walk the packet, push every expected {bit,last,stuffed}.
  task automatic push_model(input int skip, input int run_len, input logic se);
    int   run;
    logic b;
    bit   lst;
    bit   st;
    run    = 0;
    exp_sc = 0;
    for (int i = 0; i < pkt_n; i++) begin
      b   = pkt[i];
      lst = (i == pkt_n - 1);
      st  = 0;
      if (se && i >= skip) begin
        if (b) run++;
        else   run = 0;
        if (run == run_len) begin
          st  = 1;
          run = 0;
        end
      end
      exp_q.push_back({b, lst & !st, 1'b0});
      if (st) begin
        exp_q.push_back({1'b0, lst, 1'b1});
        exp_sc++;
      end
    end
  endtask

  // Drive pkt into the selected DUT and, when check is set, score the output.
  task automatic run_packet(input logic se, input bit bp, input bit check);
    int         idx;
    int         cyc;
    bit         done;
    bit         held;
    logic [2:0] held_val;
    logic [2:0] got;
    logic [2:0] e;
    idx = 0; cyc = 0; done = 0; held = 0; held_val = '0;
    pops = 0; drops = 0; last_got = '0; prev_got = '0;
    tb_out_ready = 1'b1;
    while (!done) begin
      @(negedge clock);
      tb_out_ready = bp ? ~tb_out_ready : 1'b1;
      if (idx < pkt_n) begin
        tb_in_valid = 1'b1;
        tb_in_bit   = pkt[idx];
        tb_in_last  = (idx == pkt_n - 1);
        tb_stuff_en = se;
      end else begin
        tb_in_valid = 1'b0;
        tb_in_last  = 1'b0;
      end
      #1;
      got = {obs_out_bit, obs_out_last, obs_out_stuffed};
      if (check) begin
        if (held) begin
          n_vec++;
          if ({obs_out_valid, got} !== {1'b1, held_val}) begin
            n_err++;
            $display("FAIL hold: got valid=%b word=%b required valid=1 word=%b", obs_out_valid, got, held_val);
          end
        end
        if (obs_out_valid && tb_out_ready) begin
          pops++;
          prev_got = last_got;
          last_got = got;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL extra_output: got word=%b required none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL out_word[%0d]: got {bit,last,stuffed}=%b required %b", pops - 1, got, e);
            end
          end
        end
        held = obs_out_valid && !tb_out_ready;
        if (held) held_val = got;
      end
      if (tb_in_valid && !obs_in_ready && tb_out_ready) drops++;
      if (tb_in_valid && obs_in_ready) idx++;
      cyc++;
      if (idx == pkt_n && (!check || exp_q.size() == 0)) begin
        done = 1;
      end else if (cyc >= 400) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: accepted %0d of %0d bits, %0d outputs outstanding", idx, pkt_n, exp_q.size());
        exp_q.delete();
        done = 1;
      end
    end
    @(negedge clock);
    tb_in_valid  = 1'b0;
    tb_in_last   = 1'b0;
    tb_out_ready = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_vec += 7;
      if (obs_in_ready !== 1'b1)    begin n_err++; $display("FAIL rst_in_ready[%0d]: got %b required 1", s, obs_in_ready); end
      if (obs_out_valid !== 1'b0)   begin n_err++; $display("FAIL rst_out_valid[%0d]: got %b required 0", s, obs_out_valid); end
      if (obs_out_bit !== 1'b0)     begin n_err++; $display("FAIL rst_out_bit[%0d]: got %b required 0", s, obs_out_bit); end
      if (obs_out_last !== 1'b0)    begin n_err++; $display("FAIL rst_out_last[%0d]: got %b required 0", s, obs_out_last); end
      if (obs_out_stuffed !== 1'b0) begin n_err++; $display("FAIL rst_out_stuffed[%0d]: got %b required 0", s, obs_out_stuffed); end
      if (obs_stuff_cnt !== 8'd0)   begin n_err++; $display("FAIL rst_stuff_cnt[%0d]: got %0d required 0", s, obs_stuff_cnt); end
      if (obs_busy !== 1'b0)        begin n_err++; $display("FAIL rst_busy[%0d]: got %b required 0", s, obs_busy); end
    end
    sel = 1'b0;
  endtask

  task automatic test_pid_payload();
    sel = 1'b0;
    clear_pkt();
    add_bits(32'hA5, 8);
    add_bits(32'hFF, 8);
    push_model(8, 6, 1'b1);
    run_packet(1'b1, 1'b0, 1'b1);
    n_vec += 4;
    if (pops !== 17)            begin n_err++; $display("FAIL pid_count: got %0d outputs required 17", pops); end
    if (obs_stuff_cnt !== 8'd1) begin n_err++; $display("FAIL pid_stuff_cnt: got %0d required 1", obs_stuff_cnt); end
    if (drops !== 1)            begin n_err++; $display("FAIL pid_bubbles: got %0d required 1", drops); end
    if (obs_busy !== 1'b0)      begin n_err++; $display("FAIL pid_busy: got %b required 0", obs_busy); end
  endtask

  task automatic test_stuff_on_last();
    sel = 1'b0;
    clear_pkt();
    add_bits(32'hA5, 8);
    add_bits(32'h3F, 7);
    push_model(8, 6, 1'b1);
    run_packet(1'b1, 1'b0, 1'b1);
    n_vec += 4;
    if (pops !== 16)             begin n_err++; $display("FAIL sol_count: got %0d outputs required 16", pops); end
    if (last_got !== 3'b011)     begin n_err++; $display("FAIL sol_final: got %b required 011", last_got); end
    if (prev_got !== 3'b100)     begin n_err++; $display("FAIL sol_sixth_one: got %b required 100", prev_got); end
    if (obs_stuff_cnt !== 8'd1)  begin n_err++; $display("FAIL sol_stuff_cnt: got %0d required 1", obs_stuff_cnt); end
  endtask

  task automatic test_passthrough();
    sel = 1'b0;
    clear_pkt();
    add_bits(32'hA5, 8);
    add_bits(32'hFFFFF, 20);
    push_model(8, 6, 1'b0);
    run_packet(1'b0, 1'b0, 1'b1);
    n_vec += 3;
    if (pops !== 28)            begin n_err++; $display("FAIL pt_count: got %0d outputs required 28", pops); end
    if (obs_stuff_cnt !== 8'd0) begin n_err++; $display("FAIL pt_stuff_cnt: got %0d required 0", obs_stuff_cnt); end
    if (drops !== 0)            begin n_err++; $display("FAIL pt_in_ready_drops: got %0d required 0", drops); end
  endtask

  task automatic test_backpressure();
    sel = 1'b1;
    clear_pkt();
    add_bits(32'h3F, 6);
    push_model(0, 3, 1'b1);
    run_packet(1'b1, 1'b1, 1'b1);
    n_vec += 3;
    if (pops !== 8)             begin n_err++; $display("FAIL bp_count: got %0d outputs required 8", pops); end
    if (obs_stuff_cnt !== 8'd2) begin n_err++; $display("FAIL bp_stuff_cnt: got %0d required 2", obs_stuff_cnt); end
    if (obs_busy !== 1'b0)      begin n_err++; $display("FAIL bp_busy: got %b required 0", obs_busy); end
    sel = 1'b0;
  endtask

  task automatic test_natural_zero();
    sel = 1'b0;
    clear_pkt();
    add_bits(32'hA5, 8);
    add_bits(32'h1F, 5);
    add_bits(32'h0, 1);
    add_bits(32'h3F, 6);
    push_model(8, 6, 1'b1);
    run_packet(1'b1, 1'b0, 1'b1);
    n_vec += 3;
    if (pops !== 21)         begin n_err++; $display("FAIL nz_count: got %0d outputs required 21", pops); end
    if (last_got !== 3'b011) begin n_err++; $display("FAIL nz_final: got %b required 011", last_got); end
    repeat (3) @(negedge clock);
    #1;
    n_vec++;
    if (obs_stuff_cnt !== 8'd1) begin n_err++; $display("FAIL nz_stuff_cnt_hold: got %0d required 1", obs_stuff_cnt); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    clear_pkt();
    add_bits(32'hA5, 8);
    add_bits(32'h1F, 5);
    run_packet(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b required 1", obs_busy); end
    #1 reset_n = 1'b0;
    #1;
    n_vec += 5;
    if (obs_out_valid !== 1'b0)   begin n_err++; $display("FAIL mid_out_valid: got %b required 0", obs_out_valid); end
    if (obs_out_bit !== 1'b0)     begin n_err++; $display("FAIL mid_out_bit: got %b required 0", obs_out_bit); end
    if (obs_out_last !== 1'b0)    begin n_err++; $display("FAIL mid_out_last: got %b required 0", obs_out_last); end
    if (obs_busy !== 1'b0)        begin n_err++; $display("FAIL mid_busy: got %b required 0", obs_busy); end
    if (obs_in_ready !== 1'b1)    begin n_err++; $display("FAIL mid_in_ready: got %b required 1", obs_in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    clear_pkt();
    add_bits(32'hA5, 8);
    add_bits(32'h1F, 5);
    add_bits(32'h0, 1);
    push_model(8, 6, 1'b1);
    run_packet(1'b1, 1'b0, 1'b1);
    n_vec += 2;
    if (pops !== 14)            begin n_err++; $display("FAIL mid_next_count: got %0d outputs required 14", pops); end
    if (obs_stuff_cnt !== 8'd0) begin n_err++; $display("FAIL mid_next_stuff_cnt: got %0d required 0", obs_stuff_cnt); end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_pid_payload();
    test_stuff_on_last();
    test_passthrough();
    test_backpressure();
    test_natural_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
